// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration responder.
// Contents: frame geometry, register address map, FSM state type and a
// helper that tells whether an address is a writable configuration register.
package spi_cfg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned HDR_BITS   = 8;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned ADDR_BITS  = 7;
    localparam int unsigned CNT_BITS   = 4;

    localparam logic [ADDR_BITS-1:0] ADDR_VER0 = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_VER1 = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_ADC  = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_ADCD = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_PLL  = 7'h04;
    localparam logic [ADDR_BITS-1:0] ADDR_RGT  = 7'h05;
    localparam logic [ADDR_BITS-1:0] ADDR_PWR  = 7'h06;
    localparam logic [ADDR_BITS-1:0] ADDR_STAT = 7'h07;

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } spi_state_t;

    // True for the addresses backed by a writable configuration register.
    function automatic logic is_writable(input logic [ADDR_BITS-1:0] addr);
        return (addr == ADDR_ADC) || (addr == ADDR_PLL) ||
               (addr == ADDR_RGT) || (addr == ADDR_PWR);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises the asynchronous SPI pins into clk and detects sclk edges.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cs, sclk, sdi   raw SPI pins
//   cs_s, sdi_s     synchronised chip select and data (last sync stage)
//   rise_c, fall_c  combinational one-clk sclk rise/fall strobes, aligned
//                   with sdi_s
module spi_in_sync
    import spi_cfg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sclk,
    input  logic sdi,
    output logic cs_s,
    output logic sdi_s,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sclk_d;

    // cs chain resets to 0 so a frame already running at reset release is
    // seen as "selected" until the pin genuinely goes high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= '0;
            sclk_q <= '0;
            sdi_q  <= '0;
            sclk_d <= 1'b0;
        end else begin
            cs_q   <= (cs_q   << 1) | SYNC_STAGES'(cs);
            sclk_q <= (sclk_q << 1) | SYNC_STAGES'(sclk);
            sdi_q  <= (sdi_q  << 1) | SYNC_STAGES'(sdi);
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign sdi_s  = sdi_q[SYNC_STAGES-1];
    assign rise_c = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign fall_c = ~sclk_q[SYNC_STAGES-1] & sclk_d;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder for the sensor configuration register bank.
// Frame: R/W bit (1 = read), 7 address bits MSB first, 8 data bits LSB first.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   spi_cs/sclk/sdi      SPI pins (async), spi_sdo/spi_sdo_oe read data pad
//   adc_data             live value returned at 03H
//   cfg_adc/pll/rgt/pwr  configuration registers 02H/04H/05H[0]/06H
//   wr_stb, wr_addr      committed-write pulse and its address
//   frame_done           pulse when a frame reaches 16 bits
//   abort_cnt            saturating abort count (SPI_SLAVE_STATUS_EN only)
// Build option: define SPI_SLAVE_STATUS_EN to add status register 07H.
module spi_slave_regs
    import spi_cfg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  VER0        = 8'h01,
    parameter logic [7:0]  VER1        = 8'h02,
    parameter logic [7:0]  RST_ADC     = 8'h00,
    parameter logic [7:0]  RST_PLL     = 8'h08,
    parameter logic [7:0]  RST_RGT     = 8'h00,
    parameter logic [7:0]  RST_PWR     = 8'h39
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic       spi_sdo_oe,
    input  logic [7:0] adc_data,
    output logic [7:0] cfg_adc,
    output logic [7:0] cfg_pll,
    output logic       cfg_rgt,
    output logic [7:0] cfg_pwr,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic       frame_done
`ifdef SPI_SLAVE_STATUS_EN
    ,
    output logic [3:0] abort_cnt
`endif
);

    spi_state_t           state;
    logic [CNT_BITS-1:0]  bit_cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rd_shift;
    logic [HDR_BITS-1:0]  hdr_next;
    logic [DATA_BITS-1:0] wdata_next;
    logic [DATA_BITS-1:0] rd_val;
    logic                 cs_s;
    logic                 sdi_s;
    logic                 rise_c;
    logic                 fall_c;
`ifdef SPI_SLAVE_STATUS_EN
    logic                 last_abort;
`endif

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .cs    (spi_cs),
        .sclk  (spi_sclk),
        .sdi   (spi_sdi),
        .cs_s  (cs_s),
        .sdi_s (sdi_s),
        .rise_c(rise_c),
        .fall_c(fall_c)
    );

    // Header/data as they will look after the current sclk rise, plus the
    // read mux addressed by the just-completed header.
    always_comb begin
        hdr_next                  = {addr_q, sdi_s};
        wdata_next                = wdata;
        wdata_next[bit_cnt[2:0]]  = sdi_s;
        rd_val                    = 8'h00;
        case (hdr_next[ADDR_BITS-1:0])
            ADDR_VER0: rd_val = VER0;
            ADDR_VER1: rd_val = VER1;
            ADDR_ADC:  rd_val = cfg_adc;
            ADDR_ADCD: rd_val = adc_data;
            ADDR_PLL:  rd_val = cfg_pll;
            ADDR_RGT:  rd_val = {7'b0, cfg_rgt};
            ADDR_PWR:  rd_val = cfg_pwr;
`ifdef SPI_SLAVE_STATUS_EN
            ADDR_STAT: rd_val = {abort_cnt, 3'b000, last_abort};
`endif
            default:   rd_val = 8'h00;
        endcase
    end

    // Frame FSM, shift registers and register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_CS;
            bit_cnt    <= '0;
            addr_q     <= '0;
            wdata      <= '0;
            rd_shift   <= '0;
            cfg_adc    <= RST_ADC;
            cfg_pll    <= RST_PLL;
            cfg_rgt    <= RST_RGT[0];
            cfg_pwr    <= RST_PWR;
            spi_sdo    <= 1'b0;
            spi_sdo_oe <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
            abort_cnt  <= '0;
            last_abort <= 1'b0;
`endif
        end else begin
            wr_stb     <= 1'b0;
            frame_done <= 1'b0;
            // Deselect takes priority over any sclk edge in the same clk.
            if ((state != WAIT_CS) && cs_s) begin
`ifdef SPI_SLAVE_STATUS_EN
                if ((state == CMD) || (state == WDATA) || (state == RDATA)) begin
                    if (abort_cnt != 4'hF) begin
                        abort_cnt <= abort_cnt + 4'd1;
                    end
                    last_abort <= 1'b1;
                end
`endif
                state      <= IDLE;
                bit_cnt    <= '0;
                spi_sdo_oe <= 1'b0;
                spi_sdo    <= 1'b0;
            end else begin
                case (state)
                    WAIT_CS: begin
                        if (cs_s) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (!cs_s) begin
                            bit_cnt <= '0;
                            addr_q  <= '0;
                            wdata   <= '0;
                            state   <= CMD;
                        end
                    end
                    CMD: begin
                        if (rise_c) begin
                            addr_q  <= hdr_next[ADDR_BITS-1:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == CNT_BITS'(HDR_BITS - 1)) begin
                                if (hdr_next[HDR_BITS-1]) begin
                                    rd_shift   <= rd_val;
                                    spi_sdo_oe <= 1'b1;
                                    state      <= RDATA;
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (rise_c) begin
                            wdata   <= wdata_next;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == CNT_BITS'(FRAME_BITS - 1)) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
`ifdef SPI_SLAVE_STATUS_EN
                                last_abort <= 1'b0;
`endif
                                if (is_writable(addr_q)) begin
                                    wr_stb  <= 1'b1;
                                    wr_addr <= addr_q;
                                    case (addr_q)
                                        ADDR_ADC: cfg_adc <= wdata_next;
                                        ADDR_PLL: cfg_pll <= wdata_next;
                                        ADDR_RGT: cfg_rgt <= wdata_next[0];
                                        ADDR_PWR: cfg_pwr <= wdata_next;
                                        default:  ;
                                    endcase
                                end
                            end
                        end
                    end
                    RDATA: begin
                        // Each fall presents the next bit, LSB first.
                        if (fall_c) begin
                            spi_sdo  <= rd_shift[0];
                            rd_shift <= {1'b0, rd_shift[DATA_BITS-1:1]};
                        end
                        if (rise_c) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == CNT_BITS'(FRAME_BITS - 1)) begin
                                frame_done <= 1'b1;
                                spi_sdo_oe <= 1'b0;
                                spi_sdo    <= 1'b0;
                                state      <= DONE;
`ifdef SPI_SLAVE_STATUS_EN
                                last_abort <= 1'b0;
`endif
                            end
                        end
                    end
                    DONE: begin
                        spi_sdo_oe <= 1'b0;
                        spi_sdo    <= 1'b0;
                    end
                    default: state <= WAIT_CS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: directed frames from the test plan
// followed by randomized frames, compared against a register-level model.
module tb_spi_slave_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs;
    logic       spi_sclk;
    logic       spi_sdi;
    logic       spi_sdo;
    logic       spi_sdo_oe;
    logic [7:0] adc_data;
    logic [7:0] cfg_adc;
    logic [7:0] cfg_pll;
    logic       cfg_rgt;
    logic [7:0] cfg_pwr;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic       frame_done;
`ifdef SPI_SLAVE_STATUS_EN
    logic [3:0] abort_cnt;
`endif

    int n_err = 0;
    int n_chk = 0;
    int stb_cnt = 0;
    int done_cnt = 0;
    int apart_cnt = 0;
    logic [6:0] last_waddr = 7'h00;

    // Reference model state
    logic [7:0] m_adc;
    logic [7:0] m_pll;
    logic       m_rgt;
    logic [7:0] m_pwr;
    int         m_cnt;
    logic       m_last;

    always #5 clk = ~clk;

    spi_slave_regs dut (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_sdi   (spi_sdi),
        .spi_sdo   (spi_sdo),
        .spi_sdo_oe(spi_sdo_oe),
        .adc_data  (adc_data),
        .cfg_adc   (cfg_adc),
        .cfg_pll   (cfg_pll),
        .cfg_rgt   (cfg_rgt),
        .cfg_pwr   (cfg_pwr),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .frame_done(frame_done)
`ifdef SPI_SLAVE_STATUS_EN
        ,
        .abort_cnt (abort_cnt)
`endif
    );

    // Pulse monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt    = stb_cnt + 1;
            last_waddr = wr_addr;
        end
        if (frame_done) done_cnt = done_cnt + 1;
        if (wr_stb && !frame_done) apart_cnt = apart_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_adc  = 8'h00;
        m_pll  = 8'h08;
        m_rgt  = 1'b0;
        m_pwr  = 8'h39;
        m_cnt  = 0;
        m_last = 1'b0;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a, input logic [7:0] adc);
        case (a)
            7'h00: return 8'h01;
            7'h01: return 8'h02;
            7'h02: return m_adc;
            7'h03: return adc;
            7'h04: return m_pll;
            7'h05: return {7'b0, m_rgt};
            7'h06: return m_pwr;
`ifdef SPI_SLAVE_STATUS_EN
            7'h07: return {4'(m_cnt), 3'b000, m_last};
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_regs();
        check("cfg_adc", cfg_adc, m_adc);
        check("cfg_pll", cfg_pll, m_pll);
        check("cfg_rgt", cfg_rgt, m_rgt);
        check("cfg_pwr", cfg_pwr, m_pwr);
`ifdef SPI_SLAVE_STATUS_EN
        check("abort_cnt", abort_cnt, m_cnt);
`endif
    endtask

    // One SPI frame of nbits clocks (sclk = clk/8). rst_at pulses rst after
    // that bit; cs_last raises cs together with the final sclk rise.
    task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits, input int rst_at, input bit cs_last);
        logic [7:0] rd;
        logic [7:0] exp_rd;
        logic       exp_oe;
        logic       b;
        int         stb0;
        int         done0;
        int         oe_bad;
        bit         live;
        bit         complete;
        bit         exp_stb;
        live   = 1'b1;
        rd     = 8'h00;
        oe_bad = 0;
        stb0   = stb_cnt;
        done0  = done_cnt;
        exp_rd = model_read(addr, adc_data);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) b = rw;
            else if (i < 8) b = addr[7-i];
            else if (i < 16) b = data[i-8];
            else b = 1'($urandom_range(0, 1));
            spi_sdi = b;
            repeat (4) @(negedge clk);
            exp_oe = live && rw && (i >= 8) && (i < 16);
            if (spi_sdo_oe !== exp_oe) oe_bad = oe_bad + 1;
            if (i >= 8 && i < 16) rd[i-8] = spi_sdo;
            spi_sclk = 1'b1;
            if (cs_last && i == nbits - 1) spi_cs = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                live = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);

        complete = live && (nbits >= 16) && !cs_last;
        exp_stb  = complete && !rw &&
                   (addr == 7'h02 || addr == 7'h04 || addr == 7'h05 || addr == 7'h06);
        if (exp_stb) begin
            case (addr)
                7'h02: m_adc = data;
                7'h04: m_pll = data;
                7'h05: m_rgt = data[0];
                default: m_pwr = data;
            endcase
        end
        if (complete) m_last = 1'b0;
        else if (live) begin
            if (m_cnt < 15) m_cnt = m_cnt + 1;
            m_last = 1'b1;
        end

        check("wr_stb_count", stb_cnt - stb0, exp_stb ? 1 : 0);
        check("frame_done_count", done_cnt - done0, complete ? 1 : 0);
        if (exp_stb) check("wr_addr", last_waddr, addr);
        check("sdo_oe_bits", oe_bad, 0);
        check("sdo_oe_idle", spi_sdo_oe, 1'b0);
        check("sdo_idle", spi_sdo, 1'b0);
        if (rw && complete) check("read_data", rd, exp_rd);
        check_regs();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nb;
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_sdi  = 1'b0;
        adc_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sdo", spi_sdo, 1'b0);
        check("rst_sdo_oe", spi_sdo_oe, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 7'h00);
        check("rst_frame_done", frame_done, 1'b0);
        check_regs();
        rst = 1'b0;
        repeat (6) @(negedge clk);

        run_frame(1'b0, 7'h05, 8'h01, 16, -1, 1'b0);   // write RGT
        check("rgt_set", cfg_rgt, 1'b1);
        run_frame(1'b1, 7'h01, 8'h00, 16, -1, 1'b0);   // read VER1
        adc_data = 8'hA5;
        run_frame(1'b1, 7'h03, 8'h00, 16, -1, 1'b0);   // read ADC data
        run_frame(1'b0, 7'h04, 8'hFF, 12, -1, 1'b0);   // aborted write
        check("pll_kept", cfg_pll, 8'h08);
        run_frame(1'b1, 7'h07, 8'h00, 16, -1, 1'b0);   // status read
        run_frame(1'b0, 7'h00, 8'h55, 16, -1, 1'b0);   // read-only write
        run_frame(1'b1, 7'h00, 8'h00, 16, -1, 1'b0);
        run_frame(1'b0, 7'h02, 8'h3C, 16, 4, 1'b0);    // reset after 5 bits
        run_frame(1'b0, 7'h02, 8'h3C, 16, -1, 1'b0);
        run_frame(1'b0, 7'h06, 8'h00, 20, -1, 1'b0);   // overlong frame
        check("pwr_cleared", cfg_pwr, 8'h00);
        run_frame(1'b0, 7'h04, 8'h5A, 16, -1, 1'b1);   // cs with 16th rise
        run_frame(1'b1, 7'h04, 8'h00, 20, -1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, 8));
            data = 8'($urandom);
            nb   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 16;
            adc_data = 8'($urandom);
            run_frame(rw, addr, data, nb, -1, 1'b0);
        end

        check("stb_without_done", apart_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
